// File: rtl/decode_stage_pkg.sv
// Shared opcode/func codes, field positions, FSM encodings and the D/X control bundle
// used by the decode stage and its instruction control decoder.
package decode_stage_pkg;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam logic [5:0] F2_MUL = 6'h02;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef struct packed {
    logic [5:0]  alu_funk;
    logic        alu_in_1_sel;
    logic        alu_in_2_sel;
    logic        wb_we;
    logic [4:0]  wb_reg_addr;
    logic        mem_out_sel;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        xm_o_sel;
    logic [31:0] d1_xm_o;
    logic [31:0] s_immed;
    logic        illegal;
  } dx_ctrl_t;

  localparam dx_ctrl_t CTRL_BUBBLE = '{
    alu_funk: 6'h00, alu_in_1_sel: 1'b0, alu_in_2_sel: 1'b0, wb_we: 1'b0,
    wb_reg_addr: 5'd0, mem_out_sel: 1'b1, mem_access_size: SZ_BYTE, mem_rw: 1'b1,
    xm_o_sel: 1'b0, d1_xm_o: 32'h0, s_immed: 32'h0, illegal: 1'b0
  };

endpackage

// File: rtl/decode_stage_insn_ctrl_decode.sv
// Combinational instruction decoder: one instruction word plus its PC in, the D/X
// control bundle and source-register usage flags out.
module insn_ctrl_decode
  import decode_stage_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int JAL_LINK_OFS = 8
) (
  input  logic [31:0]     insn_in,
  input  logic [PC_W-1:0] pc_in,
  output dx_ctrl_t        ctrl_o,
  output logic            uses_rs_o,
  output logic            uses_rt_o
);

  logic [5:0]      op;
  logic [5:0]      func;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [15:0]     immed;
  logic [PC_W-1:0] link_pc;
  logic            bad;

  assign op      = insn_in[OP_LSB +: 6];
  assign func    = insn_in[5:0];
  assign rt      = insn_in[RT_LSB +: 5];
  assign rd      = insn_in[RD_LSB +: 5];
  assign immed   = insn_in[15:0];
  assign link_pc = pc_in + PC_W'(JAL_LINK_OFS);

  always_comb begin
    ctrl_o         = CTRL_BUBBLE;
    ctrl_o.s_immed = {{16{immed[15]}}, immed};
    uses_rs_o      = 1'b1;
    uses_rt_o      = 1'b0;
    bad            = 1'b0;
    case (op)
      OP_SPECIAL: begin
        uses_rt_o          = 1'b1;
        ctrl_o.wb_we       = 1'b1;
        ctrl_o.wb_reg_addr = rd;
        case (func)
          F_ADD, F_ADDU: ctrl_o.alu_funk = F_ADD;
          F_SUB, F_SUBU: ctrl_o.alu_funk = F_SUB;
          F_SLT, F_SLTU, F_AND, F_OR, F_XOR, F_NOR: ctrl_o.alu_funk = func;
          F_SLL, F_SRL, F_SRA: begin
            ctrl_o.alu_funk     = func;
            ctrl_o.alu_in_1_sel = 1'b1;
            uses_rs_o           = 1'b0;
          end
          F_JR: begin
            ctrl_o.wb_we       = 1'b0;
            ctrl_o.wb_reg_addr = 5'd0;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        if (func == F2_MUL) begin
          uses_rt_o          = 1'b1;
          ctrl_o.alu_funk    = F_MULT;
          ctrl_o.wb_we       = 1'b1;
          ctrl_o.wb_reg_addr = rd;
        end else begin
          bad = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
        ctrl_o.alu_in_2_sel = 1'b1;
        ctrl_o.wb_we        = 1'b1;
        ctrl_o.wb_reg_addr  = rt;
        case (op)
          OP_SLTI:  ctrl_o.alu_funk = F_SLT;
          OP_SLTIU: ctrl_o.alu_funk = F_SLTU;
          OP_ANDI:  ctrl_o.alu_funk = F_AND;
          OP_ORI:   ctrl_o.alu_funk = F_OR;
          default:  ctrl_o.alu_funk = F_ADD;
        endcase
        if (op == OP_ANDI || op == OP_ORI) ctrl_o.s_immed = {16'h0, immed};
      end
      OP_LB, OP_LBU, OP_LW: begin
        ctrl_o.alu_funk        = F_ADD;
        ctrl_o.alu_in_2_sel    = 1'b1;
        ctrl_o.mem_out_sel     = 1'b0;
        ctrl_o.mem_access_size = (op == OP_LW) ? SZ_WORD : SZ_BYTE;
        ctrl_o.wb_we           = 1'b1;
        ctrl_o.wb_reg_addr     = rt;
      end
      OP_SB, OP_SW: begin
        uses_rt_o              = 1'b1;
        ctrl_o.alu_funk        = F_ADD;
        ctrl_o.alu_in_2_sel    = 1'b1;
        ctrl_o.mem_rw          = 1'b0;
        ctrl_o.mem_access_size = (op == OP_SW) ? SZ_WORD : SZ_BYTE;
      end
      OP_BEQ, OP_BNE: begin
        uses_rt_o       = 1'b1;
        ctrl_o.alu_funk = F_SUB;
      end
      OP_J: uses_rs_o = 1'b0;
      OP_JAL: begin
        uses_rs_o          = 1'b0;
        ctrl_o.wb_we       = 1'b1;
        ctrl_o.wb_reg_addr = 5'd31;
        ctrl_o.xm_o_sel    = 1'b1;
        ctrl_o.d1_xm_o     = 32'(link_pc);
      end
      OP_LUI: begin
        uses_rs_o          = 1'b0;
        ctrl_o.wb_we       = 1'b1;
        ctrl_o.wb_reg_addr = rt;
        ctrl_o.xm_o_sel    = 1'b1;
        ctrl_o.d1_xm_o     = {immed, 16'h0};
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl_o         = CTRL_BUBBLE;
      ctrl_o.illegal = 1'b1;
      uses_rs_o      = 1'b0;
      uses_rt_o      = 1'b0;
    end
    // r0 is hardwired, so a write there is never a real writeback or hazard source
    if (ctrl_o.wb_reg_addr == 5'd0) ctrl_o.wb_we = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: D/X pipeline register with fetch handshake, execute stall, branch flush
// and load-use bubble insertion with a saturating bubble counter.
//
// state  | meaning
// RUN    | normal flow; accepts from fetch when execute is ready and no hazard
// BUBBLE | inserting load-use bubbles; bub_left = bubbles still to insert
// HOLD   | execute stalled; D/X frozen until x_ready_in returns
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int LU_BUBBLES   = 1,
  parameter int JAL_LINK_OFS = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             fd_valid_in,
  output logic             fd_ready,
  input  logic [31:0]      insn_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             x_ready_in,
  input  logic             flush_in,
  output logic             dx_valid,
  output logic [PC_W-1:0]  dx_pc,
  output logic [31:0]      dx_ir,
  output logic [4:0]       dx_rs,
  output logic [4:0]       dx_rt,
  output logic [31:0]      dx_s_immed,
  output logic [5:0]       dx_alu_funk,
  output logic             dx_alu_in_1_sel,
  output logic             dx_alu_in_2_sel,
  output logic             dx_wb_we,
  output logic [4:0]       dx_wb_reg_addr,
  output logic             dx_mem_out_sel,
  output logic [1:0]       dx_mem_access_size,
  output logic             dx_mem_rw,
  output logic             dx_xm_o_sel,
  output logic [31:0]      dx_d1_xm_o,
  output logic             dx_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  dx_ctrl_t         dec_ctrl, ctrl_d, ctrl_q;
  logic             uses_rs, uses_rt, hazard, load_dx, load_bub;
  logic [4:0]       in_rs, in_rt;
  logic             valid_d, valid_q;
  logic [PC_W-1:0]  pc_d, pc_q;
  logic [31:0]      ir_d, ir_q;
  logic [4:0]       rs_d, rs_q, rt_d, rt_q;
  logic [1:0]       state_d, state_q;
  logic [2:0]       bub_left_d, bub_left_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;

  insn_ctrl_decode #(.PC_W(PC_W), .JAL_LINK_OFS(JAL_LINK_OFS)) u_dec (
    .insn_in  (insn_in),
    .pc_in    (pc_in),
    .ctrl_o   (dec_ctrl),
    .uses_rs_o(uses_rs),
    .uses_rt_o(uses_rt)
  );

  assign in_rs   = insn_in[RS_LSB +: 5];
  assign in_rt   = insn_in[RT_LSB +: 5];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign hazard  = valid_q & ~ctrl_q.mem_out_sel & ctrl_q.wb_we & (ctrl_q.wb_reg_addr != 5'd0)
                 & ((uses_rs & (in_rs == ctrl_q.wb_reg_addr)) | (uses_rt & (in_rt == ctrl_q.wb_reg_addr)));
  assign fd_ready = flush_in | (x_ready_in & (state_q == ST_RUN) & ~hazard);

  always_comb begin
    state_d    = state_q;
    bub_left_d = bub_left_q;
    cnt_d      = cnt_q;
    load_dx    = 1'b0;
    load_bub   = 1'b0;
    if (flush_in) begin
      load_bub   = 1'b1;
      state_d    = ST_RUN;
      bub_left_d = 3'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!x_ready_in) begin
            state_d = ST_HOLD;
          end else if (hazard && fd_valid_in) begin
            load_bub   = 1'b1;
            cnt_d      = cnt_inc;
            bub_left_d = 3'(LU_BUBBLES - 1);
            state_d    = (LU_BUBBLES > 1) ? ST_BUBBLE : ST_RUN;
          end else if (fd_valid_in) begin
            load_dx = 1'b1;
          end else begin
            load_bub = 1'b1;
          end
        end
        ST_BUBBLE: begin
          if (x_ready_in) begin
            load_bub = 1'b1;
            if (bub_left_q == 3'd0) begin
              state_d = ST_RUN;
            end else begin
              cnt_d      = cnt_inc;
              bub_left_d = bub_left_q - 3'd1;
              // leave after the last bubble so the penalty is exactly LU_BUBBLES cycles
              if (bub_left_q == 3'd1) state_d = ST_RUN;
            end
          end
        end
        ST_HOLD: begin
          // the held entry is consumed by execute on the release cycle
          if (x_ready_in) begin
            state_d  = ST_RUN;
            load_bub = 1'b1;
          end
        end
        default: begin
          state_d  = ST_RUN;
          load_bub = 1'b1;
        end
      endcase
    end

    valid_d = valid_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    ctrl_d  = ctrl_q;
    if (load_dx) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      ir_d    = insn_in;
      rs_d    = in_rs;
      rt_d    = in_rt;
      ctrl_d  = dec_ctrl;
    end else if (load_bub) begin
      valid_d = 1'b0;
      pc_d    = '0;
      ir_d    = NOP;
      rs_d    = 5'd0;
      rt_d    = 5'd0;
      ctrl_d  = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_RUN;
      bub_left_q <= 3'd0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      ir_q       <= NOP;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      ctrl_q     <= CTRL_BUBBLE;
    end else begin
      state_q    <= state_d;
      bub_left_q <= bub_left_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign dx_valid           = valid_q;
  assign dx_pc              = pc_q;
  assign dx_ir              = ir_q;
  assign dx_rs              = rs_q;
  assign dx_rt              = rt_q;
  assign dx_s_immed         = ctrl_q.s_immed;
  assign dx_alu_funk        = ctrl_q.alu_funk;
  assign dx_alu_in_1_sel    = ctrl_q.alu_in_1_sel;
  assign dx_alu_in_2_sel    = ctrl_q.alu_in_2_sel;
  assign dx_wb_we           = ctrl_q.wb_we;
  assign dx_wb_reg_addr     = ctrl_q.wb_reg_addr;
  assign dx_mem_out_sel     = ctrl_q.mem_out_sel;
  assign dx_mem_access_size = ctrl_q.mem_access_size;
  assign dx_mem_rw          = ctrl_q.mem_rw;
  assign dx_xm_o_sel        = ctrl_q.xm_o_sel;
  assign dx_d1_xm_o         = ctrl_q.d1_xm_o;
  assign dx_illegal         = ctrl_q.illegal;
  assign bubble_cnt         = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode map, load-use bubbles, stall, flush and reset.
module tb_decode_stage;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        fd_valid_in = 1'b0;
  logic        fd_ready;
  logic [31:0] insn_in = 32'h0;
  logic [31:0] pc_in = 32'h0;
  logic        x_ready_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        dx_valid;
  logic [31:0] dx_pc, dx_ir, dx_s_immed, dx_d1_xm_o;
  logic [4:0]  dx_rs, dx_rt, dx_wb_reg_addr;
  logic [5:0]  dx_alu_funk;
  logic        dx_alu_in_1_sel, dx_alu_in_2_sel, dx_wb_we, dx_mem_out_sel;
  logic [1:0]  dx_mem_access_size;
  logic        dx_mem_rw, dx_xm_o_sel, dx_illegal;
  logic [15:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  decode_stage #(.PC_W(32), .LU_BUBBLES(2), .JAL_LINK_OFS(8), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .fd_valid_in(fd_valid_in), .fd_ready(fd_ready),
    .insn_in(insn_in), .pc_in(pc_in), .x_ready_in(x_ready_in), .flush_in(flush_in),
    .dx_valid(dx_valid), .dx_pc(dx_pc), .dx_ir(dx_ir), .dx_rs(dx_rs), .dx_rt(dx_rt),
    .dx_s_immed(dx_s_immed), .dx_alu_funk(dx_alu_funk),
    .dx_alu_in_1_sel(dx_alu_in_1_sel), .dx_alu_in_2_sel(dx_alu_in_2_sel),
    .dx_wb_we(dx_wb_we), .dx_wb_reg_addr(dx_wb_reg_addr), .dx_mem_out_sel(dx_mem_out_sel),
    .dx_mem_access_size(dx_mem_access_size), .dx_mem_rw(dx_mem_rw),
    .dx_xm_o_sel(dx_xm_o_sel), .dx_d1_xm_o(dx_d1_xm_o), .dx_illegal(dx_illegal),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
    fd_valid_in = v;
    insn_in     = insn;
    pc_in       = pc;
  endtask

  initial begin
    // reset
    tick(); tick();
    rst_n_in = 1'b1;
    #1;
    chk("rst_valid", 32'(dx_valid), 32'd0);
    chk("rst_ir", dx_ir, 32'h0);
    chk("rst_mem_out_sel", 32'(dx_mem_out_sel), 32'd1);
    chk("rst_mem_rw", 32'(dx_mem_rw), 32'd1);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst_fd_ready", 32'(fd_ready), 32'd1);

    // ADDI $8,$0,-1
    tick();
    drive(1'b1, 32'h2008FFFF, 32'h100);
    #1 chk("addi_fd_ready", 32'(fd_ready), 32'd1);
    tick();
    chk("addi_valid", 32'(dx_valid), 32'd1);
    chk("addi_pc", dx_pc, 32'h100);
    chk("addi_wb_addr", 32'(dx_wb_reg_addr), 32'd8);
    chk("addi_wb_we", 32'(dx_wb_we), 32'd1);
    chk("addi_immed", dx_s_immed, 32'hFFFFFFFF);
    chk("addi_in2", 32'(dx_alu_in_2_sel), 32'd1);
    chk("addi_funk", 32'(dx_alu_funk), 32'h20);

    // JAL
    drive(1'b1, 32'h0C000040, 32'h200);
    tick();
    chk("jal_d1", dx_d1_xm_o, 32'h208);
    chk("jal_wb_addr", 32'(dx_wb_reg_addr), 32'd31);
    chk("jal_wb_we", 32'(dx_wb_we), 32'd1);
    chk("jal_xm_sel", 32'(dx_xm_o_sel), 32'd1);

    // LUI $9,0x1234
    drive(1'b1, 32'h3C091234, 32'h204);
    tick();
    chk("lui_d1", dx_d1_xm_o, 32'h12340000);
    chk("lui_wb_addr", 32'(dx_wb_reg_addr), 32'd9);
    chk("lui_xm_sel", 32'(dx_xm_o_sel), 32'd1);

    // ANDI $5,$6,0x8000: zero-extended
    drive(1'b1, 32'h30C58000, 32'h208);
    tick();
    chk("andi_immed", dx_s_immed, 32'h00008000);
    chk("andi_funk", 32'(dx_alu_funk), 32'h24);

    // SW $3,4($2)
    drive(1'b1, 32'hAC430004, 32'h20C);
    tick();
    chk("sw_rw", 32'(dx_mem_rw), 32'd0);
    chk("sw_size", 32'(dx_mem_access_size), 32'd2);
    chk("sw_wb_we", 32'(dx_wb_we), 32'd0);
    chk("sw_in2", 32'(dx_alu_in_2_sel), 32'd1);

    // SLL $2,$3,4
    drive(1'b1, 32'h00031100, 32'h210);
    tick();
    chk("sll_in1", 32'(dx_alu_in_1_sel), 32'd1);
    chk("sll_wb_addr", 32'(dx_wb_reg_addr), 32'd2);
    chk("sll_wb_we", 32'(dx_wb_we), 32'd1);

    // ADD $0,$1,$2: r0 write suppressed
    drive(1'b1, 32'h00220020, 32'h214);
    tick();
    chk("r0_valid", 32'(dx_valid), 32'd1);
    chk("r0_wb_we", 32'(dx_wb_we), 32'd0);

    // illegal opcode
    drive(1'b1, 32'hFC000000, 32'h218);
    tick();
    chk("ill_flag", 32'(dx_illegal), 32'd1);
    chk("ill_wb_we", 32'(dx_wb_we), 32'd0);
    chk("ill_rw", 32'(dx_mem_rw), 32'd1);

    // empty cycle
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("empty_valid", 32'(dx_valid), 32'd0);

    // load-use: LW $8,0($4) then ADD $10,$8,$9 with two bubbles
    drive(1'b1, 32'h8C880000, 32'h300);
    tick();
    chk("lw_mem_out_sel", 32'(dx_mem_out_sel), 32'd0);
    chk("lw_size", 32'(dx_mem_access_size), 32'd2);
    drive(1'b1, 32'h01095020, 32'h304);
    #1 chk("lu_fd_ready0", 32'(fd_ready), 32'd0);
    tick();
    chk("lu_bub1_valid", 32'(dx_valid), 32'd0);
    chk("lu_bub1_fd_ready", 32'(fd_ready), 32'd0);
    tick();
    chk("lu_bub2_valid", 32'(dx_valid), 32'd0);
    chk("lu_cnt", 32'(bubble_cnt), 32'd2);
    chk("lu_run_fd_ready", 32'(fd_ready), 32'd1);
    tick();
    chk("lu_add_valid", 32'(dx_valid), 32'd1);
    chk("lu_add_pc", dx_pc, 32'h304);
    chk("lu_add_ir", dx_ir, 32'h01095020);

    // execute stall for three cycles
    x_ready_in = 1'b0;
    drive(1'b1, 32'h2008FFFF, 32'h308);
    #1 chk("stall_fd_ready", 32'(fd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", dx_pc, 32'h304);
      chk("stall_ir", dx_ir, 32'h01095020);
    end
    x_ready_in = 1'b1;
    #1 chk("hold_fd_ready", 32'(fd_ready), 32'd0);
    tick();
    chk("release_fd_ready", 32'(fd_ready), 32'd1);
    tick();
    chk("post_stall_pc", dx_pc, 32'h308);
    chk("post_stall_valid", 32'(dx_valid), 32'd1);

    // flush during BUBBLE
    drive(1'b1, 32'h8C880000, 32'h400);
    tick();
    drive(1'b1, 32'h01095020, 32'h404);
    tick();
    chk("fl_bub_cnt", 32'(bubble_cnt), 32'd3);
    flush_in = 1'b1;
    #1 chk("fl_fd_ready", 32'(fd_ready), 32'd1);
    tick();
    flush_in = 1'b0;
    chk("fl_valid", 32'(dx_valid), 32'd0);
    chk("fl_cnt_kept", 32'(bubble_cnt), 32'd3);
    #1 chk("fl_run_fd_ready", 32'(fd_ready), 32'd1);
    tick();
    chk("fl_add_valid", 32'(dx_valid), 32'd1);
    chk("fl_add_pc", dx_pc, 32'h404);

    // asynchronous reset mid-stream
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_valid", 32'(dx_valid), 32'd0);
    chk("arst_ir", dx_ir, 32'h0);
    chk("arst_mem_out_sel", 32'(dx_mem_out_sel), 32'd1);
    chk("arst_mem_rw", 32'(dx_mem_rw), 32'd1);
    chk("arst_cnt", 32'(bubble_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
